// File: rtl/p4_box_pkg.sv
// -----------------------------------------------------------------------------
// p4_box_pkg
// Shared definitions for the P4 box ingress path.
//   - Metadata layout offsets. The tuser field sits at bit 0 and the channel
//     tag sits directly above it. The channel offset depends on the tuser
//     width of the instance, so it is provided as a function of that width.
//   - Statistics counter widths and their types.
// No ports (package).
// -----------------------------------------------------------------------------
package p4_box_pkg;

    // Metadata layout: {zero pad, CHAN_ID, tuser}
    localparam int META_TUSER_LSB = 0;

    // Channel tag starts right after the tuser field (META_CHAN_LSB = TUSER_W).
    function automatic int meta_chan_lsb(input int tuser_w);
        return META_TUSER_LSB + tuser_w;
    endfunction

    // Statistics counter widths
    localparam int STAT_PKT_W  = 32;
    localparam int STAT_BYTE_W = 48;

    typedef logic [STAT_PKT_W-1:0]  stat_pkt_t;
    typedef logic [STAT_BYTE_W-1:0] stat_byte_t;

endpackage

// File: rtl/p4_ingress_adapter_if.sv
// -----------------------------------------------------------------------------
// p4_ingress_adapter_if
// AXI4-Stream bundle used on both sides of the ingress adapter.
//   tvalid / tready : handshake
//   tdata           : TDATA_W data
//   tkeep           : TDATA_W/8 byte enables
//   tlast           : end of packet
//   tuser           : TUSER_W sideband
// Modports:
//   master : drives payload and tvalid, receives tready
//   slave  : receives payload and tvalid, drives tready
// -----------------------------------------------------------------------------
interface p4_ingress_adapter_if #(
    parameter int TDATA_W = 1024,
    parameter int TUSER_W = 64
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_W-1:0]     tdata;
    logic [TDATA_W/8-1:0]   tkeep;
    logic                   tlast;
    logic [TUSER_W-1:0]     tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/p4_axis_skid.sv
// -----------------------------------------------------------------------------
// p4_axis_skid
// Generic two-entry, full-throughput skid buffer over a WIDTH-bit payload.
// Main register M feeds the output; spare register S absorbs one beat when
// the output stalls. Upstream ready is a register output (no combinational
// path from i_ready to o_ready).
// Ports:
//   i_clk          in   clock
//   i_rst_n        in   synchronous active-low reset
//   i_valid/o_ready     upstream handshake, i_data upstream payload
//   o_valid/i_ready     downstream handshake, o_data downstream payload
//   o_m_load       out  M is written on this clock edge
//   o_m_load_data  out  value being written into M (for side registers that
//                       must stay aligned with M)
// -----------------------------------------------------------------------------
module p4_axis_skid #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_m_load,
    output logic [WIDTH-1:0] o_m_load_data
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    // Holds upstream ready low while in reset and for the reset edge itself.
    logic             r_live;

    logic             w_in_fire;
    logic             w_m_free;
    logic             w_m_load;
    logic             w_s_load;
    logic [WIDTH-1:0] w_m_load_data;

    assign o_ready   = r_live & ~r_s_valid;
    assign w_in_fire = i_valid & o_ready;

    // M can take a new value when it is empty or is handed off this cycle.
    assign w_m_free  = ~r_m_valid | i_ready;

    // S is only ever full while M is full, so a free M with a full S means
    // S is the next beat in order; the input is blocked in that case.
    assign w_m_load      = w_m_free & (r_s_valid | w_in_fire);
    assign w_m_load_data = r_s_valid ? r_s_data : i_data;
    assign w_s_load      = ~w_m_free & w_in_fire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_live    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_m_free) begin
                r_m_valid <= r_s_valid | w_in_fire;
            end
            if (w_m_load) begin
                r_m_data <= w_m_load_data;
            end
            if (w_m_free & r_s_valid) begin
                r_s_valid <= 1'b0;
            end else if (w_s_load) begin
                r_s_valid <= 1'b1;
            end
            if (w_s_load) begin
                r_s_data <= i_data;
            end
        end
    end

    assign o_valid       = r_m_valid;
    assign o_data        = r_m_data;
    assign o_m_load      = w_m_load;
    assign o_m_load_data = w_m_load_data;

endmodule

// File: rtl/p4_ingress_adapter.sv
// -----------------------------------------------------------------------------
// p4_ingress_adapter
// AXI4-Stream ingress stage for the P4 pipeline. Registers the packet stream
// through a two-entry skid buffer, tracks start-of-packet on accepted beats,
// and presents packed user metadata {zero pad, CHAN_ID, tuser@SOP} with a
// valid strobe on the first output beat of each packet.
//
// Optional feature: define P4_IN_STATS_EN to build the packet/byte counters.
// Without it both stat ports are constant 0.
//
// Ports:
//   aclk                    in   clock
//   aresetn                 in   synchronous active-low reset
//   s_axis                  slave  upstream stream (tuser sampled on SOP only)
//   m_axis                  master downstream stream to the P4 core
//   user_metadata_in        out  USERMETA_W packed metadata
//   user_metadata_in_valid  out  high while the current output beat is SOP
//   stat_pkt_cnt            out  32-bit packets forwarded
//   stat_byte_cnt           out  48-bit bytes forwarded
// -----------------------------------------------------------------------------
module p4_ingress_adapter
    import p4_box_pkg::*;
#(
    parameter int TDATA_W    = 1024,
    parameter int TUSER_W    = 64,
    parameter int CHAN_ID_W  = 4,
    parameter int CHAN_ID    = 0,
    parameter int USERMETA_W = 1088
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    p4_ingress_adapter_if.slave     s_axis,
    p4_ingress_adapter_if.master    m_axis,
    output logic [USERMETA_W-1:0]   user_metadata_in,
    output logic                    user_metadata_in_valid,
    output stat_pkt_t               stat_pkt_cnt,
    output stat_byte_t              stat_byte_cnt
);

    localparam int KEEP_W        = TDATA_W / 8;
    localparam int META_W        = TUSER_W + CHAN_ID_W;
    localparam int META_CHAN_LSB = meta_chan_lsb(TUSER_W);

    // Skid payload layout: {sop, tuser, tlast, tkeep, tdata}
    localparam int PL_DATA_LSB  = 0;
    localparam int PL_KEEP_LSB  = PL_DATA_LSB + TDATA_W;
    localparam int PL_LAST_BIT  = PL_KEEP_LSB + KEEP_W;
    localparam int PL_TUSER_LSB = PL_LAST_BIT + 1;
    localparam int PL_SOP_BIT   = PL_TUSER_LSB + TUSER_W;
    localparam int PL_W         = PL_SOP_BIT + 1;

    logic              r_in_sop;
    logic [META_W-1:0] r_meta;

    logic              w_s_ready;
    logic              w_in_fire;
    logic [PL_W-1:0]   w_in_payload;
    logic              w_m_valid;
    logic [PL_W-1:0]   w_m_payload;
    logic              w_m_load;
    logic [PL_W-1:0]   w_m_load_data;
    logic [KEEP_W-1:0] w_m_keep;
    logic              w_m_last;
    logic              w_m_sop;

    // ---------------------------------------------------------------------
    // Input side: SOP tracking on accepted beats only
    // ---------------------------------------------------------------------
    assign w_in_fire    = s_axis.tvalid & w_s_ready;
    assign w_in_payload = {r_in_sop, s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_in_sop <= 1'b1;
        end else if (w_in_fire) begin
            // The beat after a tlast beat starts a new packet.
            r_in_sop <= s_axis.tlast;
        end
    end

    p4_axis_skid #(
        .WIDTH (PL_W)
    ) u_skid (
        .i_clk         (aclk),
        .i_rst_n       (aresetn),
        .i_valid       (s_axis.tvalid),
        .o_ready       (w_s_ready),
        .i_data        (w_in_payload),
        .o_valid       (w_m_valid),
        .i_ready       (m_axis.tready),
        .o_data        (w_m_payload),
        .o_m_load      (w_m_load),
        .o_m_load_data (w_m_load_data)
    );

    assign s_axis.tready = w_s_ready;

    // ---------------------------------------------------------------------
    // Output side
    // ---------------------------------------------------------------------
    assign w_m_keep = w_m_payload[PL_KEEP_LSB +: KEEP_W];
    assign w_m_last = w_m_payload[PL_LAST_BIT];
    assign w_m_sop  = w_m_payload[PL_SOP_BIT];

    assign m_axis.tvalid = w_m_valid;
    assign m_axis.tdata  = w_m_payload[PL_DATA_LSB +: TDATA_W];
    assign m_axis.tkeep  = w_m_keep;
    assign m_axis.tlast  = w_m_last;
    assign m_axis.tuser  = w_m_payload[PL_TUSER_LSB +: TUSER_W];

    // ---------------------------------------------------------------------
    // Metadata: captured in step with M so it changes only when a new SOP
    // beat becomes the output beat; held across non-first beats and stalls.
    // ---------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_meta <= '0;
        end else if (w_m_load && w_m_load_data[PL_SOP_BIT]) begin
            r_meta[META_TUSER_LSB +: TUSER_W]  <= w_m_load_data[PL_TUSER_LSB +: TUSER_W];
            r_meta[META_CHAN_LSB +: CHAN_ID_W] <= CHAN_ID_W'(CHAN_ID);
        end
    end

    assign user_metadata_in       = USERMETA_W'(r_meta);
    assign user_metadata_in_valid = w_m_valid & w_m_sop;

    // ---------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------
`ifdef P4_IN_STATS_EN
    localparam int POP_W = $clog2(KEEP_W + 1);

    logic [POP_W-1:0] w_keep_pop;
    logic             w_out_fire;
    stat_pkt_t        r_pkt_cnt;
    stat_byte_t       r_byte_cnt;

    assign w_out_fire = w_m_valid & m_axis.tready;

    always_comb begin
        w_keep_pop = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            w_keep_pop = w_keep_pop + POP_W'(w_m_keep[i]);
        end
    end

    // Both counters wrap naturally at their register widths.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
        end else if (w_out_fire) begin
            r_byte_cnt <= r_byte_cnt + STAT_BYTE_W'(w_keep_pop);
            if (w_m_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign stat_pkt_cnt  = r_pkt_cnt;
    assign stat_byte_cnt = r_byte_cnt;
`else
    assign stat_pkt_cnt  = '0;
    assign stat_byte_cnt = '0;
`endif

endmodule
